melody_sequencer: RTL
=====================

Name: melody_sequencer

Overview:
- Plays a fixed song stored in an internal ROM by driving the eight one-hot note-select lines of the piezo tone generator.
- The tone generator divides a 1 MHz clk into notes a..ha on its piezo output.
- Sits between the play/stop buttons (debounced upstream) and the tone generator's key inputs; it replaces the physical keys when a song is playing.
- Handles tempo prescaling, note/rest timing, an articulation gap between notes, end-of-song detection and optional looping.

Parameters:
- TICK_DIV, 62500: clk cycles per duration unit (1/16 s at 1 MHz); must be ≥ 2.
- GAP_CYC, 6250: silent cycles at the end of every note; must be < TICK_DIV.
- SONG_LEN, 32: ROM depth in entries; max 256.

Ports:
- clk  in  1  system clock, 1 MHz nominal.
- reset  in  1  asynchronous, active-low.
- play  in  1  one-cycle pulse: start song from step 0.
- stop  in  1  one-cycle pulse: abort playback.
- loop_en  in  1  level: restart at step 0 after end of song.
- note_o  out  8  one-hot note select, bit0=a … bit7=ha; 0 = silence.
- busy  out  1  high while not IDLE.
- step_o  out  8  current ROM address.
- done  out  1  one-cycle pulse when a non-looping song finishes.

Behaviour:
- Reset: reset is asynchronous, active-low; clock is clk. On reset: note_o=0, busy=0, step_o=0, done=0, all counters 0, state IDLE. Reset mid-song silences note_o immediately.
- ROM entry format, 8 bits:
  - [7:4] code: 0 = rest; 1..8 = note, with note_o = 1<<(code-1); 9..14 = rest; 15 = end marker.
  - [3:0] dur in units; dur 0 means 16 units.
- FSM states: IDLE, FETCH, PLAY, FINISH.
- IDLE: note_o=0. play → FETCH, step_o=0.
- FETCH: exactly 1 cycle; the ROM output is registered into code/dur; note_o=0.
  - If code=15 → FINISH.
  - Otherwise → PLAY, with tick_cnt=0 and unit_cnt=0.
- PLAY: tick_cnt counts 0..TICK_DIV-1. On wrap, unit_cnt increments.
  - note_o = decoded code, except when unit_cnt=dur-1 and tick_cnt ≥ TICK_DIV-GAP_CYC; then note_o=0.
  - Rest codes drive 0 throughout.
  - Timing: note length is exactly dur·TICK_DIV cycles, the audible part is dur·TICK_DIV-GAP_CYC cycles, and each step period is dur·TICK_DIV+1 cycles including FETCH.
- End of PLAY, on the last unit's tick wrap:
  - If step_o=SONG_LEN-1 → FINISH.
  - Else step_o+1, then → FETCH.
- FINISH: 1 cycle, note_o=0.
  - If loop_en=1 (sampled in FINISH): step_o=0, then → FETCH; no done pulse.
  - Else: done=1 for this cycle, then → IDLE with step_o=0.
- stop has highest priority in every state: next state IDLE, note_o=0 and step_o=0 on the next edge, no done pulse. Simultaneous play+stop → stop wins.
- play while busy=1 is ignored; it does not restart the song.
- Output timing: note_o is a registered output (glitch-free, because the tone generator uses priority decode); exactly one bit or none is set.
- Width rule: tick_cnt width is clog2(TICK_DIV); unit_cnt is 4 bits and compared against dur-1 modulo 16.

Decomposition:
- Package melody_pkg:
  - note code constants (REST=0, NOTE_A=1 … NOTE_HA=8, END=15).
  - entry field positions.
  - default song table.
  - function code→one-hot.
- Sub-module melody_rom: synchronous-read case ROM, address step_o, 1-cycle latency, content from melody_pkg.
- Sequencer FSM and counters stay in melody_sequencer.

Test Plan:
- Bench setup: TICK_DIV=10, GAP_CYC=2, SONG_LEN=4; ROM = 0x12, 0x01, 0x51, 0xF0.
- Play: play pulse at cycle 0 → busy=1 at cycle 1; note_o=0x01 for cycles 2..19; 0x00 for cycles 20..22; 0x00 rest for cycles 23..32; note_o=0x10 for cycles 34..41; FINISH after the end marker; done pulse once; busy=0.
- Loop: loop_en=1 → after the end marker the sequencer restarts with note_o=0x01 again and done is never asserted; step_o returns to 0.
- Stop mid-note: stop pulse in cycle 10 → note_o=0, busy=0, step_o=0 on the next edge; no done pulse.
- Boundaries:
  - play+stop in the same IDLE cycle → remains IDLE.
  - play during PLAY → timing unchanged from the play scenario.
  - Reset asserted mid-note → note_o=0 asynchronously.
- ROM with dur 0 (0x30) and no end marker over SONG_LEN=4 → note_o=0x04 for 158 cycles, then gap; after step 3 → FINISH, done pulse.

Source files
------------

// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared types, note codes, entry layout and default song for the melody sequencer
package melody_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_PLAY   = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam logic [3:0] CODE_REST = 4'd0;
   localparam logic [3:0] NOTE_A    = 4'd1;
   localparam logic [3:0] NOTE_H    = 4'd2;
   localparam logic [3:0] NOTE_C    = 4'd3;
   localparam logic [3:0] NOTE_D    = 4'd4;
   localparam logic [3:0] NOTE_E    = 4'd5;
   localparam logic [3:0] NOTE_F    = 4'd6;
   localparam logic [3:0] NOTE_G    = 4'd7;
   localparam logic [3:0] NOTE_HA   = 4'd8;
   localparam logic [3:0] CODE_END  = 4'd15;

   // Entry layout: code in the upper nibble, duration in units in the lower one.
   localparam int CODE_MSB = 7;
   localparam int CODE_LSB = 4;
   localparam int DUR_MSB  = 3;
   localparam int DUR_LSB  = 0;

   // Song table is a packed vector, entry i at bits [8*i +: 8].
   localparam int SONG_MAX  = 256;
   localparam int SONG_BITS = SONG_MAX * 8;

   localparam logic [SONG_BITS-1:0] DEFAULT_SONG = {
      {((SONG_MAX - 32) * 8){1'b0}},
      8'hF0, 8'h04, 8'h72, 8'h82, 8'h04, 8'h18, 8'h22, 8'h22,
      8'h22, 8'h22, 8'h34, 8'h34, 8'h42, 8'h42, 8'h42, 8'h42,
      8'h58, 8'h62, 8'h62, 8'h62, 8'h62, 8'h58, 8'h62, 8'h62,
      8'h62, 8'h62, 8'h54, 8'h54, 8'h42, 8'h32, 8'h22, 8'h12
   };

   // Note codes 1..8 select one key line; every other code is silence.
   function automatic logic [7:0] code_to_onehot(input logic [3:0] code);
      logic [7:0] oh;
      oh = 8'h00;
      if (code >= NOTE_A && code <= NOTE_HA) begin
         oh = 8'h01 << (code - 4'd1);
      end
      return oh;
   endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - synchronous-read song ROM with one cycle of latency
module melody_rom
   import melody_pkg::*;
#(
   parameter int                    SONG_LEN = 32,
   parameter logic [SONG_BITS-1:0]  SONG     = DEFAULT_SONG
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] addr_i,
   output logic [7:0] data_o
);

   logic [7:0] data_q;

   // Registered read; addresses past the song read as an end marker.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= 8'h00;
      end else if (int'(addr_i) < SONG_LEN) begin
         data_q <= SONG[{addr_i, 3'b000} +: 8];
      end else begin
         data_q <= {CODE_END, 4'h0};
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - plays the ROM song on the one-hot tone generator key lines
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int                    TICK_DIV = 62500,
   parameter int                    GAP_CYC  = 6250,
   parameter int                    SONG_LEN = 32,
   parameter logic [SONG_BITS-1:0]  SONG     = DEFAULT_SONG
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       play,
   input  logic       stop,
   input  logic       loop_en,
   output logic [7:0] note_o,
   output logic       busy,
   output logic [7:0] step_o,
   output logic       done
);

   localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   state_t        state_q, state_d;
   logic [7:0]    step_q, step_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [3:0]    unit_q, unit_d;
   logic [3:0]    code_q, code_d;
   logic [3:0]    dur_q, dur_d;
   logic [7:0]    note_q, note_d;
   logic [7:0]    rom_data;
   logic          tick_wrap;
   logic          last_unit;
   logic          in_gap;

   // The ROM is addressed with the next step so its data matches step_o during FETCH.
   melody_rom #(
      .SONG_LEN (SONG_LEN),
      .SONG     (SONG)
   ) u_rom (
      .clk    (clk),
      .reset  (reset),
      .addr_i (step_d),
      .data_o (rom_data)
   );

   assign tick_wrap = (tick_q == TICK_LAST);
   assign last_unit = (unit_q == (dur_q - 4'd1));

   // Next-state, counters and the next registered note value.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      tick_d  = tick_q;
      unit_d  = unit_q;
      code_d  = code_q;
      dur_d   = dur_q;
      note_d  = 8'h00;
      in_gap  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (play) begin
               state_d = ST_FETCH;
               step_d  = 8'd0;
            end
         end
         ST_FETCH: begin
            code_d = rom_data[CODE_MSB:CODE_LSB];
            dur_d  = rom_data[DUR_MSB:DUR_LSB];
            if (code_d == CODE_END) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_PLAY;
               tick_d  = '0;
               unit_d  = 4'd0;
            end
         end
         ST_PLAY: begin
            if (tick_wrap) begin
               tick_d = '0;
               unit_d = unit_q + 4'd1;
               if (last_unit) begin
                  if (step_q == 8'(SONG_LEN - 1)) begin
                     state_d = ST_FINISH;
                  end else begin
                     step_d  = step_q + 8'd1;
                     state_d = ST_FETCH;
                  end
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         ST_FINISH: begin
            step_d  = 8'd0;
            state_d = loop_en ? ST_FETCH : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (stop) begin
         state_d = ST_IDLE;
         step_d  = 8'd0;
      end

      // Silence the tail of the last unit so consecutive notes are articulated.
      if (state_d == ST_PLAY) begin
         in_gap = (unit_d == (dur_d - 4'd1)) && (int'(tick_d) >= TICK_DIV - GAP_CYC);
         note_d = in_gap ? 8'h00 : code_to_onehot(code_d);
      end
   end

   // State and counter registers; reset silences the key lines immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         step_q  <= 8'd0;
         tick_q  <= '0;
         unit_q  <= 4'd0;
         code_q  <= 4'd0;
         dur_q   <= 4'd0;
         note_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         tick_q  <= tick_d;
         unit_q  <= unit_d;
         code_q  <= code_d;
         dur_q   <= dur_d;
         note_q  <= note_d;
      end
   end

   assign note_o = note_q;
   assign step_o = step_q;
   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_FINISH) && !loop_en && !stop;

endmodule
